aer_event_receiver: RTL and testbench

AER_EVENT_RECEIVER -- requirements
Module: aer_event_receiver

---
 rtl/aer_pkg.sv | 14 +
 rtl/sync_fifo.sv | 65 ++++++
 rtl/aer_event_receiver.sv | 85 ++++++++
 tb/tb_aer_event_receiver.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/aer_pkg.sv
// Shared definitions for the AER event receiver: default widths and the
// request/acknowledge handshake state encoding.
package aer_pkg;

   localparam int AER_ADDR_W = 4;
   localparam int AER_TS_W   = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACK  = 2'd1,
      GAP  = 2'd2
   } aer_state_e;

endpackage : aer_pkg

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO: the head entry is read combinationally from
// storage; pointers wrap naturally because DEPTH is a power of two.
module sync_fifo #(
   parameter int WIDTH = 20,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic [$clog2(DEPTH):0]   level_o,
   output logic                     full_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    level_q, level_d;
   logic             push_en;
   logic             pop_en;

   // Full and empty both come from the registered level, so a same-cycle pop
   // never frees space for a same-cycle push.
   assign full_o  = (level_q == LW'(DEPTH));
   assign push_en = push_i && !full_o;
   assign pop_en  = pop_i && (level_q != '0);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push_en) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_en)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push_en, pop_en})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_en) mem_q[wr_ptr_q] <= wdata_i;
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign level_o = level_q;

endmodule : sync_fifo

// File: rtl/aer_event_receiver.sv
// AER receiver: captures arbiter requests with a timestamp into a FIFO using
// an IDLE -> ACK -> GAP handshake so each neuron gets a cycle to retract.
module aer_event_receiver
   import aer_pkg::*;
#(
   parameter int ADDR_W = AER_ADDR_W,
   parameter int TS_W   = AER_TS_W,
   parameter int DEPTH  = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     spike_in,
   input  logic [ADDR_W-1:0]        address_in,
   output logic                     ack_out,
   input  logic                     tick_en,
   output logic                     evt_valid,
   input  logic                     evt_ready,
   output logic [ADDR_W-1:0]        evt_addr,
   output logic [TS_W-1:0]          evt_time,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic                     full
);

   localparam int EW = ADDR_W + TS_W;

   aer_state_e          state_q, state_d;
   logic                ack_q, ack_d;
   logic [TS_W-1:0]     ts_q, ts_d;
   logic                push;
   logic                pop;
   logic [EW-1:0]       head_data;

   always_comb begin
      state_d = state_q;
      push    = 1'b0;
      case (state_q)
         IDLE: begin
            if (spike_in && !full) begin
               push    = 1'b1;
               state_d = ACK;
            end
         end
         ACK:     state_d = GAP;
         GAP:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Acknowledge is a flop that mirrors the ACK state, never a decode glitch.
   assign ack_d = (state_d == ACK);
   assign ts_d  = tick_en ? ts_q + TS_W'(1) : ts_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ack_q   <= 1'b0;
         ts_q    <= '0;
      end else begin
         state_q <= state_d;
         ack_q   <= ack_d;
         ts_q    <= ts_d;
      end
   end

   assign evt_valid = (fifo_level != '0);
   assign pop       = evt_valid && evt_ready;

   sync_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .wdata_i ({address_in, ts_q}),
      .pop_i   (pop),
      .rdata_o (head_data),
      .level_o (fifo_level),
      .full_o  (full)
   );

   assign {evt_addr, evt_time} = head_data;
   assign ack_out              = ack_q;

endmodule : aer_event_receiver

// File: tb/tb_aer_event_receiver.sv
// Directed bench for aer_event_receiver: handshake timing, FIFO order,
// backpressure, timestamp wrap, simultaneous push/pop and reset abort.
module tb_aer_event_receiver;

   logic        clk;
   logic        rst_n;
   logic        spike_in;
   logic [3:0]  address_in;
   logic        ack_out;
   logic        tick_en;
   logic        evt_valid;
   logic        evt_ready;
   logic [3:0]  evt_addr;
   logic [15:0] evt_time;
   logic [3:0]  fifo_level;
   logic        full;

   int tests  = 0;
   int failed = 0;

   aer_event_receiver #(
      .ADDR_W (4),
      .TS_W   (16),
      .DEPTH  (8)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .spike_in   (spike_in),
      .address_in (address_in),
      .ack_out    (ack_out),
      .tick_en    (tick_en),
      .evt_valid  (evt_valid),
      .evt_ready  (evt_ready),
      .evt_addr   (evt_addr),
      .evt_time   (evt_time),
      .fifo_level (fifo_level),
      .full       (full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp)
      else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
      $display("[TB] check %s observed=%0h expected=%0h", tag, got, exp);
   endtask

   initial begin
      int acks;
      int ack_cyc [4];

      rst_n = 1'b0; spike_in = 1'b0; address_in = '0; tick_en = 1'b0; evt_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ack", ack_out, 0);
      chk("rst_valid", evt_valid, 0);
      chk("rst_full", full, 0);
      chk("rst_level", fifo_level, 0);

      // Single event with timestamp 0x0010 at push
      rst_n = 1'b1; tick_en = 1'b1;
      repeat (16) @(negedge clk);
      chk("t1_ack_before", ack_out, 0);
      spike_in = 1'b1; address_in = 4'd5;
      @(negedge clk);
      chk("t1_ack", ack_out, 1);
      chk("t1_valid", evt_valid, 1);
      chk("t1_addr", evt_addr, 5);
      chk("t1_time", evt_time, 16'h0010);
      chk("t1_level", fifo_level, 1);
      spike_in = 1'b0; evt_ready = 1'b1; tick_en = 1'b0;   // timestamp frozen at 17
      @(negedge clk);
      chk("t1_ack_gap", ack_out, 0);
      chk("t1_level_after", fifo_level, 0);
      chk("t1_valid_after", evt_valid, 0);
      evt_ready = 1'b0;
      @(negedge clk);

      // Sustained request, address advances on each ack
      spike_in = 1'b1; address_in = 4'd0; acks = 0;
      for (int i = 0; i < 4; i++) ack_cyc[i] = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (ack_out) begin
            if (acks < 4) ack_cyc[acks] = c;
            acks++;
            address_in = address_in + 4'd1;
         end
      end
      spike_in = 1'b0;
      chk("t2_acks", acks, 4);
      chk("t2_spacing1", ack_cyc[1] - ack_cyc[0], 3);
      chk("t2_spacing3", ack_cyc[3] - ack_cyc[0], 9);
      chk("t2_level", fifo_level, 4);
      evt_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("t2_addr%0d", i), evt_addr, i);
         chk($sformatf("t2_time%0d", i), evt_time, 16'd17);
         @(negedge clk);
      end
      evt_ready = 1'b0;
      chk("t2_drained", fifo_level, 0);

      // Backpressure: 9 requests into an 8-deep FIFO
      spike_in = 1'b1; address_in = 4'd0; acks = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (ack_out) begin
            acks++;
            address_in = address_in + 4'd1;
         end
      end
      chk("t3_acks", acks, 8);
      chk("t3_full", full, 1);
      chk("t3_level", fifo_level, 8);
      chk("t3_head", evt_addr, 0);
      evt_ready = 1'b1;
      @(negedge clk);
      evt_ready = 1'b0;
      chk("t3_no_push_on_pop", ack_out, 0);
      chk("t3_level_pop", fifo_level, 7);
      @(negedge clk);
      chk("t3_ack9", ack_out, 1);
      chk("t3_level9", fifo_level, 8);
      chk("t3_full9", full, 1);
      spike_in = 1'b0;
      evt_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         chk($sformatf("t3_order%0d", i), evt_addr, i);
         @(negedge clk);
      end
      evt_ready = 1'b0;
      chk("t3_drained", fifo_level, 0);

      // Timestamp wrap: 17 + 65518 ticks = 0xFFFF
      tick_en = 1'b1;
      repeat (65518) @(negedge clk);
      spike_in = 1'b1; address_in = 4'hA;
      @(negedge clk);
      chk("t4_ack_a", ack_out, 1);
      tick_en = 1'b0; address_in = 4'hB;
      repeat (3) @(negedge clk);
      chk("t4_ack_b", ack_out, 1);
      spike_in = 1'b0;
      chk("t4_level", fifo_level, 2);
      chk("t4_addr_a", evt_addr, 4'hA);
      chk("t4_time_a", evt_time, 16'hFFFF);
      evt_ready = 1'b1;
      @(negedge clk);
      chk("t4_addr_b", evt_addr, 4'hB);
      chk("t4_time_b", evt_time, 16'h0000);
      @(negedge clk);
      evt_ready = 1'b0;
      chk("t4_drained", fifo_level, 0);

      // Simultaneous push and pop at level 3
      spike_in = 1'b1; address_in = 4'd1;
      for (int c = 0; c < 9; c++) begin
         @(negedge clk);
         if (ack_out) address_in = address_in + 4'd1;
      end
      chk("t5_level_pre", fifo_level, 3);
      chk("t5_addr_next", address_in, 4);
      evt_ready = 1'b1;
      @(negedge clk);
      evt_ready = 1'b0; spike_in = 1'b0;
      chk("t5_ack", ack_out, 1);
      chk("t5_level", fifo_level, 3);
      chk("t5_head", evt_addr, 2);

      // Reset asserted while in ACK
      rst_n = 1'b0;
      #1;
      chk("t6_ack_async", ack_out, 0);
      chk("t6_level_async", fifo_level, 0);
      chk("t6_valid_async", evt_valid, 0);
      @(negedge clk);
      rst_n = 1'b1; spike_in = 1'b1; address_in = 4'd7;
      @(negedge clk);
      spike_in = 1'b0;
      chk("t6_first_push_ack", ack_out, 1);
      chk("t6_first_push_level", fifo_level, 1);
      chk("t6_first_push_addr", evt_addr, 7);
      chk("t6_first_push_time", evt_time, 16'h0000);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule : tb_aer_event_receiver
